// File: rtl/dtc_frame_aligner.sv
// -----------------------------------------------------------------------------
// dtc_frame_aligner
//
// Recovers 256-bit frame alignment from a serial, LSB-first CIC bit stream.
// A three-state tracker runs the alignment:
//   HUNT - slides an 8-bit window over every accepted bit, looking for HEADER.
//   SYNC - counts bits to the frame boundary, then re-checks the header.
//          LOCK_N consecutive good headers (counting the one found in HUNT)
//          promote it to LOCK. A single bad header sends it back to HUNT.
//   LOCK - emits every frame with a good header. A bad header gives an error
//          pulse. MISS_MAX consecutive bad headers drop it back to HUNT.
//
// Ports
//   clk          in   1    rising-edge clock
//   rst          in   1    synchronous active-high reset
//   sr_in        in   1    serial data bit (frame bit 0 is sent first)
//   sr_valid     in   1    qualifies sr_in; nothing moves while it is low
//   frame_out    out  256  last emitted aligned frame (held between emissions)
//   frame_valid  out  1    one-cycle pulse when frame_out carries a new frame
//   frame_err    out  1    one-cycle pulse on a bad header while locked
//   locked       out  1    high while in LOCK
//   frame_cnt    out  16   number of emitted frames (wraps)
// -----------------------------------------------------------------------------
module dtc_frame_aligner #(
    parameter logic [7:0] HEADER   = 8'hA5,
    parameter int         LOCK_N   = 3,
    parameter int         MISS_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sr_in,
    input  logic         sr_valid,
    output logic [255:0] frame_out,
    output logic         frame_valid,
    output logic         frame_err,
    output logic         locked,
    output logic [15:0]  frame_cnt
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_N_C   = 8'(LOCK_N);
    localparam logic [7:0] MISS_MAX_C = 8'(MISS_MAX);

    state_t         r_state;
    logic [255:0]   r_asm;
    logic [7:0]     r_win;
    logic [7:0]     r_bit_cnt;
    logic [7:0]     r_good_cnt;
    logic [7:0]     r_miss_cnt;
    logic [255:0]   r_frame_out;
    logic           r_frame_valid;
    logic           r_frame_err;
    logic           r_locked;
    logic [15:0]    r_frame_cnt;

    logic [255:0]   w_asm_next;
    logic [7:0]     w_win_next;
    logic           w_frame_done;
    logic           w_hdr_good;
    logic [7:0]     w_good_inc;
    logic [7:0]     w_miss_inc;

    // Header decisions look at the shift results that include the bit being
    // accepted this cycle, so the decision and the shift share one edge.
    always_comb begin
        w_asm_next   = {sr_in, r_asm[255:1]};
        w_win_next   = {sr_in, r_win[7:1]};
        w_frame_done = (r_state != HUNT) && (r_bit_cnt == 8'hFF);
        w_hdr_good   = (w_asm_next[7:0] == HEADER);
        w_good_inc   = r_good_cnt + 8'd1;
        w_miss_inc   = r_miss_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= HUNT;
            r_asm         <= '0;
            r_win         <= '0;
            r_bit_cnt     <= '0;
            r_good_cnt    <= '0;
            r_miss_cnt    <= '0;
            r_frame_out   <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            // Pulses default low; they only rise on a completion edge.
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;

            if (sr_valid) begin
                r_asm <= w_asm_next;
                r_win <= w_win_next;

                case (r_state)
                    HUNT: begin
                        // Header occupies frame bits 0..7, so the next
                        // accepted bit is frame bit 8.
                        if (w_win_next == HEADER) begin
                            r_state    <= SYNC;
                            r_bit_cnt  <= 8'd8;
                            r_good_cnt <= 8'd1;
                        end
                    end

                    SYNC: begin
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (w_frame_done) begin
                            if (w_hdr_good) begin
                                r_good_cnt <= w_good_inc;
                                if (w_good_inc == LOCK_N_C) begin
                                    r_state    <= LOCK;
                                    r_miss_cnt <= '0;
                                    r_locked   <= 1'b1;
                                end
                            end else begin
                                // Window restarts empty so stale bits of the
                                // bad frame cannot fake a header.
                                r_state <= HUNT;
                                r_win   <= '0;
                            end
                        end
                    end

                    LOCK: begin
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (w_frame_done) begin
                            if (w_hdr_good) begin
                                r_frame_out   <= w_asm_next;
                                r_frame_valid <= 1'b1;
                                r_frame_cnt   <= r_frame_cnt + 16'd1;
                                r_miss_cnt    <= '0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_miss_cnt  <= w_miss_inc;
                                if (w_miss_inc == MISS_MAX_C) begin
                                    r_state  <= HUNT;
                                    r_win    <= '0;
                                    r_locked <= 1'b0;
                                end
                            end
                        end
                    end

                    default: begin
                        r_state <= HUNT;
                        r_win   <= '0;
                    end
                endcase
            end
        end
    end

    assign frame_out   = r_frame_out;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign locked      = r_locked;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_dtc_frame_aligner.sv
// -----------------------------------------------------------------------------
// tb_dtc_frame_aligner
//
// Drives serial frames into dtc_frame_aligner. Every frame that should be
// emitted is pushed to a scoreboard queue together with its expected count
// before it is sent; a negedge monitor pops and compares on each frame_valid.
// Each scenario task also checks pulse timing, lock status and held outputs.
// -----------------------------------------------------------------------------
module tb_dtc_frame_aligner;

    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [7:0] BAD = 8'h5A;

    typedef struct {
        logic [255:0] frame;
        logic [15:0]  cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sr_in;
    logic         sr_valid;
    logic [255:0] frame_out;
    logic         frame_valid;
    logic         frame_err;
    logic         locked;
    logic [15:0]  frame_cnt;

    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         exp_q[$];
    logic [15:0]  exp_cnt = 16'd0;
    bit           locked_seen = 1'b0;

    dtc_frame_aligner #(
        .HEADER   (8'hA5),
        .LOCK_N   (3),
        .MISS_MAX (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sr_in       (sr_in),
        .sr_valid    (sr_valid),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .locked      (locked),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every frame_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (locked === 1'b1) locked_seen = 1'b1;
        if (frame_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame_valid: got frame_out[31:0]=%h cnt=%0d, required no emission",
                         frame_out[31:0], frame_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (frame_out !== e.frame || frame_cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL scoreboard_frame: got frame_out[63:0]=%h cnt=%0d, required frame[63:0]=%h cnt=%0d",
                             frame_out[63:0], frame_cnt, e.frame[63:0], e.cnt);
                end else begin
                    $display("[TB] frame #%0d emitted ok, header=%h", frame_cnt, frame_out[7:0]);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] make_frame(input logic [7:0] hdr);
        logic [255:0] f;
        for (int w = 0; w < 8; w++) f[w*32 +: 32] = $urandom;
        f[7:0] = hdr;
        return f;
    endfunction

    // True when no 8-bit window of junk followed by the header's first bits
    // matches HEADER before the real header completes.
    function automatic bit junk_ok(input logic [12:0] j);
        logic [20:0] s;
        s = {HDR, j};
        for (int k = 0; k < 13; k++) begin
            if (s[k +: 8] == HDR) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_exp(input logic [255:0] f);
        exp_t e;
        exp_cnt = exp_cnt + 16'd1;
        e.frame = f;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic b, input int gap_pct);
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            sr_valid = 1'b0;
            sr_in    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        sr_valid = 1'b1;
        sr_in    = b;
        @(posedge clk); #1;
        sr_valid = 1'b0;
    endtask

    // Sends one frame LSB-first; returns the pulses seen right after bit 255.
    task automatic send_frame(input logic [255:0] f, input int gap_pct,
                              output logic v, output logic e);
        for (int i = 0; i < 256; i++) drive_bit(f[i], gap_pct);
        v = frame_valid;
        e = frame_err;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        sr_valid = 1'b0;
        sr_in    = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst      = 1'b0;
        exp_cnt  = 16'd0;
        locked_seen = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        sr_valid = 1'b1;          // reset must win over valid data
        sr_in    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (frame_out !== 256'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0 ||
            locked !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out[31:0]=%h v=%b e=%b l=%b cnt=%0d, required all zero",
                     frame_out[31:0], frame_valid, frame_err, locked, frame_cnt);
        end
        sr_valid = 1'b0;
        rst      = 1'b0;
        exp_cnt  = 16'd0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_back_to_back();
        logic [255:0] p[4];
        logic v, e;
        do_reset();
        for (int k = 0; k < 4; k++) p[k] = make_frame(HDR);
        send_frame(p[0], 0, v, e);
        n_tests++;
        if (locked !== 1'b0 || v !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_frame0: got locked=%b valid=%b, required 0 0", locked, v);
        end
        send_frame(p[1], 0, v, e);
        n_tests++;
        if (locked !== 1'b1 || v !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_lock_after_frame1: got locked=%b valid=%b, required 1 0", locked, v);
        end
        for (int k = 2; k < 4; k++) begin
            push_exp(p[k]);
            send_frame(p[k], 0, v, e);
            n_tests++;
            if (v !== 1'b1 || e !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_emit_%0d: got valid=%b err=%b, required 1 0", k, v, e);
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (frame_valid !== 1'b0 || frame_out !== p[3] || frame_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_final: got valid=%b out[31:0]=%h cnt=%0d, required 0 %h 2",
                     frame_valid, frame_out[31:0], frame_cnt, p[3][31:0]);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_hunt_junk();
        logic [12:0]  junk;
        logic [255:0] f[3];
        logic v, e;
        do_reset();
        junk = 13'($urandom);
        for (int t = 0; t < 1000 && !junk_ok(junk); t++) junk = 13'($urandom);
        if (!junk_ok(junk)) junk = 13'd0;
        for (int i = 0; i < 13; i++) drive_bit(junk[i], 0);
        for (int k = 0; k < 3; k++) f[k] = make_frame(HDR);
        send_frame(f[0], 0, v, e);
        send_frame(f[1], 0, v, e);
        push_exp(f[2]);
        send_frame(f[2], 0, v, e);
        n_tests++;
        if (v !== 1'b1 || frame_out[7:0] !== HDR || frame_out !== f[2]) begin
            n_fail++;
            $display("FAIL hunt_align: got valid=%b out[31:0]=%h, required 1 %h",
                     v, frame_out[31:0], f[2][31:0]);
        end
        $display("[TB] test_hunt_junk done (junk=%h)", junk);
    endtask

    // Continues from the locked state left by test_hunt_junk.
    task automatic test_miss();
        logic [255:0] held, g;
        logic v, e;
        held = frame_out;
        for (int k = 0; k < 3; k++) begin
            send_frame(make_frame(BAD), 0, v, e);
            n_tests++;
            if (e !== 1'b1 || v !== 1'b0 || locked !== 1'b1 || frame_out !== held) begin
                n_fail++;
                $display("FAIL miss_bad_%0d: got err=%b valid=%b locked=%b, required 1 0 1 with frame held",
                         k, e, v, locked);
            end
        end
        g = make_frame(HDR);
        push_exp(g);
        send_frame(g, 0, v, e);
        n_tests++;
        if (v !== 1'b1 || e !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_recover: got valid=%b err=%b locked=%b, required 1 0 1", v, e, locked);
        end
        for (int k = 0; k < 4; k++) begin
            send_frame(make_frame(BAD), 0, v, e);
            n_tests++;
            if (e !== 1'b1 || locked !== ((k < 3) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL miss_drop_%0d: got err=%b locked=%b, required 1 %b",
                         k, e, locked, (k < 3) ? 1'b1 : 1'b0);
            end
        end
        $display("[TB] test_miss done");
    endtask

    task automatic test_gaps();
        logic [255:0] f0, f1, g, h;
        logic v, e;
        do_reset();
        f0 = make_frame(HDR);
        f1 = make_frame(HDR);
        send_frame(f0, 0, v, e);
        send_frame(f1, 0, v, e);
        g = make_frame(HDR);
        push_exp(g);
        send_frame(g, 50, v, e);
        n_tests++;
        if (v !== 1'b1 || frame_out !== g) begin
            n_fail++;
            $display("FAIL gaps_latency: got valid=%b out[31:0]=%h, required 1 %h", v, frame_out[31:0], g[31:0]);
        end
        for (int c = 0; c < 5; c++) begin
            sr_valid = 1'b0;
            sr_in    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n_tests++;
            if (frame_valid !== 1'b0 || frame_err !== 1'b0 || frame_cnt !== 16'd1 || frame_out !== g) begin
                n_fail++;
                $display("FAIL gaps_idle_%0d: got valid=%b err=%b cnt=%0d, required 0 0 1 with frame held",
                         c, frame_valid, frame_err, frame_cnt);
            end
        end
        h = make_frame(HDR);
        push_exp(h);
        send_frame(h, 30, v, e);
        n_tests++;
        if (v !== 1'b1 || frame_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL gaps_followup: got valid=%b cnt=%0d, required 1 2", v, frame_cnt);
        end
        $display("[TB] test_gaps done");
    endtask

    task automatic test_sync_fail();
        logic v, e;
        do_reset();
        send_frame(make_frame(HDR), 0, v, e);
        send_frame(make_frame(BAD), 0, v, e);
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (locked_seen !== 1'b0 || v !== 1'b0 || e !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL sync_fail: got locked_seen=%b valid=%b err=%b cnt=%0d, required 0 0 0 0",
                     locked_seen, v, e, frame_cnt);
        end
        $display("[TB] test_sync_fail done");
    endtask

    task automatic test_reset_mid();
        logic [255:0] f2, f3, g2;
        logic v, e;
        do_reset();
        send_frame(make_frame(HDR), 0, v, e);
        send_frame(make_frame(HDR), 0, v, e);
        f2 = make_frame(HDR);
        push_exp(f2);
        send_frame(f2, 0, v, e);
        f3 = make_frame(HDR);
        for (int i = 0; i < 100; i++) drive_bit(f3[i], 0);
        rst      = 1'b1;
        sr_valid = 1'b1;
        sr_in    = f3[100];
        @(posedge clk); #1;
        rst      = 1'b0;
        sr_valid = 1'b0;
        exp_cnt  = 16'd0;
        n_tests++;
        if (frame_out !== 256'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0 ||
            locked !== 1'b0 || frame_cnt !== 16'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid: got out[31:0]=%h v=%b e=%b l=%b cnt=%0d pending=%0d, required all zero",
                     frame_out[31:0], frame_valid, frame_err, locked, frame_cnt, exp_q.size());
        end
        send_frame(make_frame(HDR), 0, v, e);
        n_tests++;
        if (locked !== 1'b0 || v !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_relock0: got locked=%b valid=%b, required 0 0", locked, v);
        end
        send_frame(make_frame(HDR), 0, v, e);
        n_tests++;
        if (locked !== 1'b1 || v !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_relock1: got locked=%b valid=%b, required 1 0", locked, v);
        end
        g2 = make_frame(HDR);
        push_exp(g2);
        send_frame(g2, 0, v, e);
        n_tests++;
        if (v !== 1'b1 || frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_mid_emit: got valid=%b cnt=%0d, required 1 1", v, frame_cnt);
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        rst      = 1'b1;
        sr_valid = 1'b0;
        sr_in    = 1'b0;
        test_reset();
        test_back_to_back();
        test_hunt_junk();
        test_miss();
        test_gaps();
        test_sync_fail();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending frames, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
